// File: rtl/gci_std_display_vram_pkg.sv
// Shared VRAM arbitration package: FSM state encoding and address width.
// Used by both the responder and the requester side.
package gci_std_display_vram_pkg;

  localparam int VRAM_ADDR_N = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ACTIVE,
    ST_DRAIN
  } vram_state_e;

endpackage

// File: rtl/gci_std_display_vram_return_fifo.sv
// Read-return FIFO: single clock, synchronous reset, occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module gci_std_display_vram_return_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 32
) (
  input  logic                       iCLOCK,
  input  logic                       iRESET_SYNC,
  input  logic                       iPUSH,
  input  logic [P_WIDTH-1:0]         iDATA,
  input  logic                       iPOP,
  output logic [P_WIDTH-1:0]         oDATA,
  output logic                       oEMPTY,
  output logic [$clog2(P_DEPTH):0]   oCOUNT
);

  localparam int AW = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [AW-1:0]      wr_q;
  logic [AW-1:0]      rd_q;
  logic [AW:0]        cnt_q;
  logic [AW:0]        cnt_d;
  logic               full_w;

  assign full_w = (cnt_q == (AW+1)'(P_DEPTH));
  assign oEMPTY = (cnt_q == '0);
  assign oCOUNT = cnt_q;
  assign oDATA  = mem_q[rd_q];
  assign cnt_d  = cnt_q + (AW+1)'(iPUSH) - (AW+1)'(iPOP);

  always_ff @(posedge iCLOCK) begin
    if (iPUSH) begin
      mem_q[wr_q] <= iDATA;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (iPUSH) wr_q <= wr_q + AW'(1);
      if (iPOP)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Credit accounting upstream must never let this happen.
  always_ff @(posedge iCLOCK) begin
    if (!iRESET_SYNC) begin
      assert (!(iPUSH && full_w));
    end
  end

endmodule

// File: rtl/gci_std_display_vram_responder.sv
// VRAM ownership responder with credit-limited, in-order read return.
// GCI_STD_DISPLAY_VRAM_TIMEOUT_EN builds the idle forced-release counter.
module gci_std_display_vram_responder
  import gci_std_display_vram_pkg::*;
#(
  parameter int P_MEM_ADDR_N = VRAM_ADDR_N,
  parameter int P_RET_DEPTH  = 4,
  parameter int P_TIMEOUT    = 255
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET_SYNC,
  input  logic                    iVRAM_ARBIT_REQ,
  output logic                    oVRAM_ARBIT_ACK,
  input  logic                    iVRAM_ARBIT_FINISH,
  input  logic                    iVRAM_ENA,
  output logic                    oVRAM_BUSY,
  input  logic                    iVRAM_RW,
  input  logic [P_MEM_ADDR_N-1:0] iVRAM_ADDR,
  input  logic [31:0]             iVRAM_DATA,
  output logic                    oVRAM_VALID,
  input  logic                    iVRAM_BUSY,
  output logic [31:0]             oVRAM_DATA,
  output logic                    oMEM_ENA,
  output logic                    oMEM_WE,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [31:0]             oMEM_DATA,
  input  logic [31:0]             iMEM_DATA,
  output logic                    oTIMEOUT
);

  localparam int CW = $clog2(P_RET_DEPTH);

  vram_state_e state_q, state_d;

  logic                    rd1_q;
  logic                    rd2_q;
  logic                    mem_ena_q;
  logic                    mem_we_q;
  logic [P_MEM_ADDR_N-1:0] mem_addr_q;
  logic [31:0]             mem_data_q;

  logic [CW:0]   cnt_w;
  logic          empty_w;
  logic [31:0]   head_w;
  logic [CW+1:0] credit_w;
  logic          busy_w;
  logic          accept_w;
  logic          pop_w;
  logic          finish_w;
  logic          tmo_w;

  // Credits cover both buffered words and reads still in the memory pipe.
  assign credit_w = {1'b0, cnt_w} + (CW+2)'(rd1_q) + (CW+2)'(rd2_q);
  assign busy_w   = (state_q != ST_ACTIVE) ||
                    (credit_w >= (CW+2)'(P_RET_DEPTH));
  assign accept_w = iVRAM_ENA && !busy_w;
  assign pop_w    = !empty_w && !iVRAM_BUSY;
  assign finish_w = iVRAM_ARBIT_FINISH || tmo_w;

  assign oVRAM_ARBIT_ACK = (state_q == ST_GRANT);
  assign oVRAM_BUSY      = busy_w;
  assign oVRAM_VALID     = !empty_w;
  assign oVRAM_DATA      = empty_w ? 32'h0 : head_w;
  assign oMEM_ENA        = mem_ena_q;
  assign oMEM_WE         = mem_we_q;
  assign oMEM_ADDR       = mem_addr_q;
  assign oMEM_DATA       = mem_data_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (iVRAM_ARBIT_REQ) state_d = ST_GRANT;
      ST_GRANT:  state_d = ST_ACTIVE;
      ST_ACTIVE: if (finish_w) state_d = ST_DRAIN;
      ST_DRAIN:  if (empty_w && !rd1_q && !rd2_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q    <= ST_IDLE;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      mem_ena_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd1_q     <= accept_w && !iVRAM_RW;
      rd2_q     <= rd1_q;
      mem_ena_q <= accept_w;
      mem_we_q  <= accept_w && iVRAM_RW;
      if (accept_w) begin
        mem_addr_q <= iVRAM_ADDR;
        mem_data_q <= iVRAM_DATA;
      end
    end
  end

`ifdef GCI_STD_DISPLAY_VRAM_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);

  logic [TW-1:0] tmr_q, tmr_d;

  assign tmo_w = (state_q == ST_ACTIVE) && (tmr_q == TW'(P_TIMEOUT));
  assign tmr_d = (state_q == ST_ACTIVE && !accept_w) ?
                 tmr_q + TW'(1) : '0;
  assign oTIMEOUT = tmo_w;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) tmr_q <= '0;
    else             tmr_q <= tmr_d;
  end
`else
  logic [31:0] tmo_unused_w;

  assign tmo_unused_w = P_TIMEOUT;
  assign tmo_w        = 1'b0;
  assign oTIMEOUT     = 1'b0;
`endif

  gci_std_display_vram_return_fifo #(
    .P_DEPTH (P_RET_DEPTH),
    .P_WIDTH (32)
  ) u_ret_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (rd2_q),
    .iDATA       (iMEM_DATA),
    .iPOP        (pop_w),
    .oDATA       (head_w),
    .oEMPTY      (empty_w),
    .oCOUNT      (cnt_w)
  );

endmodule
